// File: rtl/flag_ctrl.sv
// flag_ctrl: CPU status-flag register {N,Z,O,C} = flags[3:0] (C=bit0 .. N=bit3)
// with a single-grant arbiter over three flag writers:
//   restore (pop) > save (push + clear) > flag-op (set/clear one bit) > ALU update.
// At most one update is applied per cycle. The update is registered, so the new
// flags are visible the cycle after the grant.
//
// Build option:
//   FLAG_CTRL_STACK_EN  - when defined, the interrupt flag stack, the save/restore
//                         path and the one-cycle SETTLE state after a restore exist.
//                         When undefined, save/restore are ignored and only
//                         fop > alu are arbitrated.
//
// Ports:
//   clk, reset_n                      clock (rising edge), async active-low reset
//   alu_valid/alu_flags/alu_mask      ALU update request (mask bit 1 = take new bit)
//   alu_ready                         ALU grant (combinational)
//   fop_valid/fop_code                flag-op request ([2] set/clear, [1:0] bit index)
//   fop_ready                         flag-op grant (combinational)
//   save_req/save_ack                 push flags and clear them
//   restore_req/restore_ack           pop flags
//   flags                             current flag register
//   stk_full/stk_empty                stack occupancy (follow the stack pointer)
//   stk_err                           one-cycle pulse after push-on-full / pop-on-empty
module flag_ctrl #(
  parameter int         STACK_DEPTH = 4,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       alu_valid,
  input  logic [3:0] alu_flags,
  input  logic [3:0] alu_mask,
  output logic       alu_ready,
  input  logic       fop_valid,
  input  logic [2:0] fop_code,
  output logic       fop_ready,
  input  logic       save_req,
  output logic       save_ack,
  input  logic       restore_req,
  output logic       restore_ack,
  output logic [3:0] flags,
  output logic       stk_full,
  output logic       stk_empty,
  output logic       stk_err
);

  typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_t;

  state_t state, state_nxt;

`ifdef FLAG_CTRL_STACK_EN
  // sp counts 0..STACK_DEPTH, so it needs one bit more than the entry index.
  localparam int IW  = $clog2(STACK_DEPTH);
  localparam int SPW = IW + 1;

  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_dec;
  logic [3:0]     stack [STACK_DEPTH];
  logic           push_ok, pop_ok;

  assign stk_full  = (sp == SPW'(STACK_DEPTH));
  assign stk_empty = (sp == '0);
  assign sp_dec    = sp - SPW'(1);
  assign push_ok   = save_ack    && !stk_full;
  assign pop_ok    = restore_ack && !stk_empty;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: only a restore that actually pops goes through SETTLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = pop_ok ? SETTLE : IDLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant outputs: fixed priority, forced low in reset and in SETTLE.
  always_comb begin
    restore_ack = 1'b0;
    save_ack    = 1'b0;
    fop_ready   = 1'b0;
    alu_ready   = 1'b0;
    if (reset_n && state == IDLE) begin
      if      (restore_req) restore_ack = 1'b1;
      else if (save_req)    save_ack    = 1'b1;
      else if (fop_valid)   fop_ready   = 1'b1;
      else if (alu_valid)   alu_ready   = 1'b1;
    end
  end

  // Flag register, stack pointer and error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags   <= RESET_FLAGS;
      sp      <= '0;
      stk_err <= 1'b0;
    end else begin
      stk_err <= 1'b0;
      if (restore_ack) begin
        if (stk_empty) stk_err <= 1'b1;
        else begin
          flags <= stack[sp_dec[IW-1:0]];
          sp    <= sp_dec;
        end
      end else if (save_ack) begin
        if (stk_full) stk_err <= 1'b1;
        else begin
          flags <= 4'b0000;
          sp    <= sp + SPW'(1);
        end
      end else if (fop_ready) begin
        flags[fop_code[1:0]] <= fop_code[2];
      end else if (alu_ready) begin
        flags <= (flags & ~alu_mask) | (alu_flags & alu_mask);
      end
    end
  end

  // Stack storage needs no reset: entries are only read below sp.
  always_ff @(posedge clk) begin
    if (push_ok) stack[sp[IW-1:0]] <= flags;
  end

`else
  // Stackless build: save/restore inputs are intentionally ignored.
  localparam int unused_depth = STACK_DEPTH;
  logic unused_req;
  assign unused_req = save_req ^ restore_req;

  assign stk_full    = 1'b0;
  assign stk_empty   = 1'b1;
  assign stk_err     = 1'b0;
  assign save_ack    = 1'b0;
  assign restore_ack = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // SETTLE is unreachable without the stack.
  always_comb begin
    state_nxt = IDLE;
  end

  always_comb begin
    fop_ready = 1'b0;
    alu_ready = 1'b0;
    if (reset_n && state == IDLE) begin
      if      (fop_valid) fop_ready = 1'b1;
      else if (alu_valid) alu_ready = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags <= RESET_FLAGS;
    end else if (fop_ready) begin
      flags[fop_code[1:0]] <= fop_code[2];
    end else if (alu_ready) begin
      flags <= (flags & ~alu_mask) | (alu_flags & alu_mask);
    end
  end
`endif

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed self-checking bench for flag_ctrl (STACK_DEPTH=4, RESET_FLAGS=0).
// Stack-specific steps are compiled only when FLAG_CTRL_STACK_EN is defined;
// otherwise the stackless behaviour is checked instead.
module tb_flag_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       alu_valid, fop_valid, save_req, restore_req;
  logic [3:0] alu_flags, alu_mask;
  logic [2:0] fop_code;
  logic       alu_ready, fop_ready, save_ack, restore_ack;
  logic [3:0] flags;
  logic       stk_full, stk_empty, stk_err;

  int nchk = 0;
  int nfail = 0;

  flag_ctrl #(.STACK_DEPTH(4), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_flags(alu_flags), .alu_mask(alu_mask), .alu_ready(alu_ready),
    .fop_valid(fop_valid), .fop_code(fop_code), .fop_ready(fop_ready),
    .save_req(save_req), .save_ack(save_ack),
    .restore_req(restore_req), .restore_ack(restore_ack),
    .flags(flags), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; fop_valid = 0; save_req = 0; restore_req = 0;
    alu_flags = 0; alu_mask = 0; fop_code = 0;
  endtask

  task automatic do_fop(input logic [2:0] code);
    fop_valid = 1; fop_code = code; #1;
    chk("fop_ready", {3'b0, fop_ready}, 4'd1);
    tick(); fop_valid = 0;
  endtask

`ifdef FLAG_CTRL_STACK_EN
  task automatic do_save();
    save_req = 1; #1;
    chk("save_ack", {3'b0, save_ack}, 4'd1);
    tick(); save_req = 0;
  endtask

  // Restore of a non-empty stack, including the SETTLE cycle.
  task automatic do_restore(input logic [3:0] exp_flags);
    restore_req = 1; #1;
    chk("restore_ack", {3'b0, restore_ack}, 4'd1);
    tick(); restore_req = 0; alu_valid = 1; #1;
    chk("settle_flags", flags, exp_flags);
    chk("settle_alu_ready", {3'b0, alu_ready}, 4'd0);
    alu_valid = 0;
    tick();
  endtask
`endif

  initial begin
    reset_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    // Reset state: grants held low even with requests present.
    alu_valid = 1; fop_valid = 1; save_req = 1; restore_req = 1; #1;
    chk("rst_flags", flags, 4'b0000);
    chk("rst_alu_ready", {3'b0, alu_ready}, 4'd0);
    chk("rst_fop_ready", {3'b0, fop_ready}, 4'd0);
    chk("rst_acks", {2'b0, save_ack, restore_ack}, 4'd0);
    chk("rst_stk", {1'b0, stk_full, stk_empty, stk_err}, 4'b0010);
    idle_inputs();
    reset_n = 1;
    tick();

    // ALU masked update.
    alu_valid = 1; alu_mask = 4'b1111; alu_flags = 4'b1010; #1;
    chk("alu_ready", {3'b0, alu_ready}, 4'd1);
    tick();
    chk("alu_load", flags, 4'b1010);
    alu_mask = 4'b0101; alu_flags = 4'b0111;
    tick();
    chk("alu_masked", flags, 4'b1111);
    alu_mask = 4'b0000; alu_flags = 4'b0000;
    tick(); alu_valid = 0;
    chk("alu_mask0", flags, 4'b1111);

    // fop beats alu in the same cycle; alu lands next cycle.
    do_fop(3'b000);
    chk("fop_clr_c", flags, 4'b1110);
    fop_valid = 1; fop_code = 3'b100;
    alu_valid = 1; alu_mask = 4'b0001; alu_flags = 4'b0000; #1;
    chk("arb_fop_ready", {3'b0, fop_ready}, 4'd1);
    chk("arb_alu_ready", {3'b0, alu_ready}, 4'd0);
    tick(); fop_valid = 0; #1;
    chk("arb_fop_result", flags, 4'b1111);
    chk("arb_alu_ready2", {3'b0, alu_ready}, 4'd1);
    tick(); alu_valid = 0;
    chk("arb_alu_result", flags, 4'b1110);
    do_fop(3'b011);
    chk("fop_clr_n", flags, 4'b0110);

`ifdef FLAG_CTRL_STACK_EN
    // Save then restore; save beats a concurrent ALU request.
    save_req = 1; alu_valid = 1; alu_mask = 4'b1111; alu_flags = 4'b1001; #1;
    chk("save_vs_alu", {2'b0, save_ack, alu_ready}, 4'b0010);
    tick(); save_req = 0; alu_valid = 0;
    chk("save_clears", flags, 4'b0000);
    chk("save_not_empty", {3'b0, stk_empty}, 4'd0);
    do_restore(4'b0110);
    chk("restore_empty", {3'b0, stk_empty}, 4'd1);
    alu_valid = 1; tick(); alu_valid = 0;
    chk("alu_after_settle", flags, 4'b1001);

    // Simultaneous save+restore: restore first, save after SETTLE.
    do_save();
    do_fop(3'b100);
    chk("pre_both", flags, 4'b0001);
    save_req = 1; restore_req = 1; #1;
    chk("both_grant", {2'b0, save_ack, restore_ack}, 4'b0001);
    tick(); restore_req = 0; #1;
    chk("both_settle_save_ack", {3'b0, save_ack}, 4'd0);
    chk("both_settle_flags", flags, 4'b1001);
    tick();
    chk("both_save_late", {3'b0, save_ack}, 4'd1);
    tick(); save_req = 0;
    chk("both_save_flags", flags, 4'b0000);
    do_restore(4'b1001);

    // Fill to full, overflow, drain, underflow.
    do_save();                 // push 1001
    do_fop(3'b100); do_save(); // push 0001
    do_fop(3'b101); do_save(); // push 0010
    do_fop(3'b110); do_save(); // push 0100
    chk("full_stk", {1'b0, stk_full, stk_empty, stk_err}, 4'b0100);
    do_fop(3'b111);
    chk("pre_ovf_flags", flags, 4'b1000);
    do_save();
    chk("ovf_err", {1'b0, stk_full, stk_empty, stk_err}, 4'b0101);
    chk("ovf_flags", flags, 4'b1000);
    tick();
    chk("ovf_err_clear", {3'b0, stk_err}, 4'd0);
    do_restore(4'b0100);
    chk("after_pop_full", {3'b0, stk_full}, 4'd0);
    do_restore(4'b0010);
    do_restore(4'b0001);
    do_restore(4'b1001);
    chk("drained", {1'b0, stk_full, stk_empty, stk_err}, 4'b0010);
    restore_req = 1; #1;
    chk("unf_ack", {3'b0, restore_ack}, 4'd1);
    tick(); restore_req = 0; alu_valid = 1; alu_mask = 4'b0000; #1;
    chk("unf_err", {1'b0, stk_full, stk_empty, stk_err}, 4'b0011);
    chk("unf_flags", flags, 4'b1001);
    chk("unf_no_settle", {3'b0, alu_ready}, 4'd1);
    tick(); alu_valid = 0;
    chk("unf_err_clear", {3'b0, stk_err}, 4'd0);

    // Reset mid-save with flags=1111.
    alu_valid = 1; alu_mask = 4'b1111; alu_flags = 4'b1111;
    tick(); alu_valid = 0;
    chk("pre_rst_flags", flags, 4'b1111);
    save_req = 1; #1;
    chk("mid_save_ack", {3'b0, save_ack}, 4'd1);
    #2 reset_n = 0; #1;
    chk("mid_rst_flags", flags, 4'b0000);
    chk("mid_rst_acks", {save_ack, restore_ack, fop_ready, alu_ready}, 4'b0000);
    chk("mid_rst_stk", {1'b0, stk_full, stk_empty, stk_err}, 4'b0010);
    tick(); save_req = 0; reset_n = 1;
    tick();
    chk("post_rst_flags", flags, 4'b0000);
    chk("post_rst_empty", {3'b0, stk_empty}, 4'd1);
`else
    // Stackless: save/restore ignored, fop still served.
    save_req = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("nostk_save_ack", {3'b0, save_ack}, 4'd0);
      tick();
    end
    chk("nostk_flags", flags, 4'b0110);
    chk("nostk_stk", {1'b0, stk_full, stk_empty, stk_err}, 4'b0010);
    restore_req = 1;
    do_fop(3'b111);
    chk("nostk_fop", flags, 4'b1110);
    chk("nostk_restore_ack", {3'b0, restore_ack}, 4'd0);
    alu_valid = 1; alu_mask = 4'b0001; alu_flags = 4'b0001; #1;
    chk("nostk_alu_ready", {3'b0, alu_ready}, 4'd1);
    tick(); alu_valid = 0; save_req = 0; restore_req = 0;
    chk("nostk_alu", flags, 4'b1111);
    alu_valid = 1; #1;
    #2 reset_n = 0; #1;
    chk("nostk_rst_flags", flags, 4'b0000);
    chk("nostk_rst_ready", {2'b0, fop_ready, alu_ready}, 4'd0);
    alu_valid = 0;
    tick(); reset_n = 1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
